// File: rtl/upe_pkg.sv
// Shared types and size helpers for the UPE sequential multi-operand adder.
package upe_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_e;

    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ext_f(input int nops);
        return clog2_f(nops);
    endfunction

    function automatic int tw_f(input int width, input int nops);
        return width + ext_f(nops);
    endfunction

    function automatic int nchunk_f(input int width, input int nops, input int chunk);
        return (tw_f(width, nops) + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/upe_csa.sv
// Combinational 3:2 carry-save compressor; carry vector is pre-shifted left by one.
module upe_csa #(
    parameter int WIDTH = 34
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH-1:0] maj;

    always_comb begin
        s   = a ^ b ^ x;
        maj = (a & b) | (a & x) | (b & x);
        // The majority MSB falls off the top; the sum cannot exceed WIDTH bits.
        c   = {maj[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/upe_multiadd.sv
// Sequential multi-operand adder: carry-save accumulation of NOPS operands,
// then a chunked carry-propagate resolve into a held valid/ready result.
module upe_multiadd
    import upe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NOPS  = 3,
    parameter int CHUNK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cin,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic [ext_f(NOPS)-1:0]   out_carry
);

    localparam int EXT    = ext_f(NOPS);
    localparam int TW     = tw_f(WIDTH, NOPS);
    localparam int NCHUNK = nchunk_f(WIDTH, NOPS, CHUNK);
    localparam int BW     = clog2_f(NOPS);
    localparam int KW     = clog2_f(NCHUNK + 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [KW-1:0]   chunk_q, chunk_d;
    logic [TW-1:0]   s_q, s_d;
    logic [TW-1:0]   c_q, c_d;
    logic            carry_q, carry_d;
    logic [TW-1:0]   res_q, res_d;
    logic            out_valid_q, out_valid_d;

    logic [TW-1:0]   x_ext;
    logic [TW-1:0]   csa_s;
    logic [TW-1:0]   csa_c;
    logic            accept;
    logic [31:0]     off;
    logic [CHUNK:0]  chunk_sum;
    logic [TW-1:0]   res_merge;

    upe_csa #(.WIDTH(TW)) u_csa (
        .a (s_q),
        .b (c_q),
        .x (x_ext),
        .s (csa_s),
        .c (csa_c)
    );

    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = out_valid_q;
    assign out_sum   = res_q[WIDTH-1:0];
    assign out_carry = res_q[TW-1:WIDTH];

    always_comb begin
        x_ext  = {{EXT{1'b0}}, in_data};
        accept = in_valid && in_ready;
        off    = 32'(chunk_q) * 32'(CHUNK);
        chunk_sum = {1'b0, CHUNK'(s_q >> off)} + {1'b0, CHUNK'(c_q >> off)}
                  + {{CHUNK{1'b0}}, carry_q};
        // Bits of a partial top chunk that land above TW are shifted out here.
        res_merge = (res_q & ~(TW'({CHUNK{1'b1}}) << off))
                  | (TW'(chunk_sum[CHUNK-1:0]) << off);
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        chunk_d     = chunk_q;
        s_d         = s_q;
        c_d         = c_q;
        carry_d     = carry_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (beat_q == '0) begin
                        s_d = x_ext;
                        c_d = {{(TW-1){1'b0}}, cin};
                    end else begin
                        s_d = csa_s;
                        c_d = csa_c;
                    end
                    if (beat_q == BW'(NOPS - 1)) begin
                        beat_d  = '0;
                        chunk_d = '0;
                        carry_d = 1'b0;
                        state_d = RESOLVE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            RESOLVE: begin
                res_d   = res_merge;
                carry_d = chunk_sum[CHUNK];
                if (chunk_q == KW'(NCHUNK - 1)) begin
                    chunk_d     = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    chunk_d = chunk_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            beat_q      <= '0;
            chunk_q     <= '0;
            s_q         <= '0;
            c_q         <= '0;
            carry_q     <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            chunk_q     <= chunk_d;
            s_q         <= s_d;
            c_q         <= c_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_upe_multiadd.sv
// Bench for upe_multiadd: default build (32b x 3, chunk 8) and a 16b x 5, chunk 4 build.
module tb_upe_multiadd;

    logic        clk;
    logic        rst;

    logic        a_cin, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_sum;
    logic [1:0]  a_out_carry;

    logic        b_cin, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data, b_out_sum;
    logic [2:0]  b_out_carry;

    upe_multiadd u_dut_a (
        .clk(clk), .rst(rst), .cin(a_cin),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_carry(a_out_carry)
    );

    upe_multiadd #(.WIDTH(16), .NOPS(5), .CHUNK(4)) u_dut_b (
        .clk(clk), .rst(rst), .cin(b_cin),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_carry(b_out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nfail = 0;

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] exp_a, exp_b;
    int a_beats = 0, a_start = 0, a_lat = 0, a_hs = 0, a_viol = 0;
    int b_beats = 0, b_start = 0, b_lat = 0, b_hs = 0, b_viol = 0;
    bit a_busy = 0, b_busy = 0, a_prev_ov = 0, b_prev_ov = 0;

    typedef struct {
        logic        c;
        logic [31:0] o0, o1, o2;
        logic [31:0] es;
        logic [1:0]  ec;
        int          lat;
        bit          tog;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Scoreboard monitors: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            a_beats = 0; a_busy = 0; a_prev_ov = 0;
        end else begin
            if (a_busy && a_in_ready) a_viol++;
            if (a_in_valid && a_in_ready) begin
                if (a_beats == 0) a_start = cyc;
                a_beats++;
                if (a_beats == 3) begin a_beats = 0; a_busy = 1; end
            end
            if (a_out_valid && !a_prev_ov) a_lat = cyc - a_start;
            a_prev_ov = a_out_valid;
            if (a_out_valid && a_out_ready) begin
                nvec++;
                if (qa.size() == 0) begin
                    nfail++;
                    $display("FAIL a_result: got 0x%0h, want none queued", {a_out_carry, a_out_sum});
                end else begin
                    exp_a = qa.pop_front();
                    if ({30'b0, a_out_carry, a_out_sum} !== exp_a) begin
                        nfail++;
                        $display("FAIL a_result: got 0x%0h, want 0x%0h", {a_out_carry, a_out_sum}, exp_a);
                    end
                end
                a_busy = 0;
                a_hs++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_beats = 0; b_busy = 0; b_prev_ov = 0;
        end else begin
            if (b_busy && b_in_ready) b_viol++;
            if (b_in_valid && b_in_ready) begin
                if (b_beats == 0) b_start = cyc;
                b_beats++;
                if (b_beats == 5) begin b_beats = 0; b_busy = 1; end
            end
            if (b_out_valid && !b_prev_ov) b_lat = cyc - b_start;
            b_prev_ov = b_out_valid;
            if (b_out_valid && b_out_ready) begin
                nvec++;
                if (qb.size() == 0) begin
                    nfail++;
                    $display("FAIL b_result: got 0x%0h, want none queued", {b_out_carry, b_out_sum});
                end else begin
                    exp_b = qb.pop_front();
                    if ({45'b0, b_out_carry, b_out_sum} !== exp_b) begin
                        nfail++;
                        $display("FAIL b_result: got 0x%0h, want 0x%0h", {b_out_carry, b_out_sum}, exp_b);
                    end
                end
                b_busy = 0;
                b_hs++;
            end
        end
    end

    task automatic send_a(input logic c, input logic [31:0] o0, input logic [31:0] o1,
                          input logic [31:0] o2, input bit tog);
        logic [31:0] ops[3];
        ops[0] = o0; ops[1] = o1; ops[2] = o2;
        for (int i = 0; i < 3; i++) begin
            int n;
            n = 0;
            a_in_valid = 1'b1;
            a_in_data  = ops[i];
            a_cin      = (i == 0) ? c : ~c;
            while (!a_in_ready && n < 100) begin @(posedge clk); #1; n++; end
            if (!a_in_ready) check("a_in_ready_timeout", 64'(a_in_ready), 64'd1);
            @(posedge clk); #1;
            if (tog) begin
                a_in_valid = 1'b0;
                a_in_data  = $urandom;
                @(posedge clk); #1;
            end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic c, input logic [15:0] o0, input logic [15:0] o1,
                          input logic [15:0] o2, input logic [15:0] o3, input logic [15:0] o4);
        logic [15:0] ops[5];
        ops[0] = o0; ops[1] = o1; ops[2] = o2; ops[3] = o3; ops[4] = o4;
        for (int i = 0; i < 5; i++) begin
            int n;
            n = 0;
            b_in_valid = 1'b1;
            b_in_data  = ops[i];
            b_cin      = (i == 0) ? c : ~c;
            while (!b_in_ready && n < 100) begin @(posedge clk); #1; n++; end
            if (!b_in_ready) check("b_in_ready_timeout", 64'(b_in_ready), 64'd1);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
    endtask

    task automatic wait_hs_a(input int target);
        int n;
        n = 0;
        while (a_hs < target && n < 200) begin @(posedge clk); n++; end
        if (a_hs < target) check("a_handshake_timeout", 64'(a_hs), 64'(target));
        #1;
    endtask

    task automatic wait_hs_b(input int target);
        int n;
        n = 0;
        while (b_hs < target && n < 200) begin @(posedge clk); n++; end
        if (b_hs < target) check("b_handshake_timeout", 64'(b_hs), 64'(target));
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held_sum;
        logic [1:0]  held_carry;
        int          hold_bad;
        int          n;
        logic [31:0] r0, r1, r2;
        logic [15:0] q0, q1, q2, q3, q4;
        logic        rc;

        tbl[0] = '{1'b1, 32'h34D51531, 32'hEEEEEEEE, 32'h11111111, 32'h34D51531, 2'd1, 8,  1'b0};
        tbl[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2'd2, 8,  1'b0};
        tbl[2] = '{1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 2'd0, 8,  1'b0};
        tbl[3] = '{1'b1, 32'h34D51531, 32'hEEEEEEEE, 32'h11111111, 32'h34D51531, 2'd1, 10, 1'b1};
        tbl[4] = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 2'd1, 8,  1'b0};

        rst = 1'b1;
        a_cin = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 1;
        b_cin = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_sum", 64'(a_out_sum), 64'd0);
        check("rst_out_carry", 64'(a_out_carry), 64'd0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
        check("post_rst_b_in_ready", 64'(b_in_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            qa.push_back({30'b0, tbl[i].ec, tbl[i].es});
            send_a(tbl[i].c, tbl[i].o0, tbl[i].o1, tbl[i].o2, tbl[i].tog);
            wait_hs_a(a_hs + 1);
            check($sformatf("latency_vec%0d", i), 64'(a_lat), 64'(tbl[i].lat));
        end

        // Back-pressure: result held while out_ready stays low.
        a_out_ready = 1'b0;
        qa.push_back(64'h13);
        send_a(1'b1, 32'd5, 32'd6, 32'd7, 1'b0);
        n = 0;
        while (!a_out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("hold_valid_rise", 64'(a_out_valid), 64'd1);
        held_sum = a_out_sum;
        held_carry = a_out_carry;
        hold_bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!a_out_valid || a_in_ready || a_out_sum !== held_sum || a_out_carry !== held_carry)
                hold_bad++;
        end
        check("hold_stable", 64'(hold_bad), 64'd0);
        a_out_ready = 1'b1;
        wait_hs_a(a_hs + 1);
        check("after_hs_in_ready", 64'(a_in_ready), 64'd1);
        check("after_hs_out_valid", 64'(a_out_valid), 64'd0);
        check("after_hs_sum_held", {32'b0, a_out_sum}, 64'h13);

        // Abort during RESOLVE chunk 2; the aborted sum must never appear.
        send_a(1'b0, 32'hAAAAAAAA, 32'h55555555, 32'h12345678, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", 64'(a_out_valid), 64'd0);
        check("abort_out_sum", 64'(a_out_sum), 64'd0);
        check("abort_out_carry", 64'(a_out_carry), 64'd0);
        check("abort_in_ready_in_rst", 64'(a_in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready_after", 64'(a_in_ready), 64'd1);
        qa.push_back(64'd6);
        send_a(1'b0, 32'd1, 32'd2, 32'd3, 1'b0);
        wait_hs_a(a_hs + 1);
        check("latency_after_abort", 64'(a_lat), 64'd8);

        for (int i = 0; i < 6; i++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; rc = 1'($urandom_range(1));
            if (i == 1) begin r0 = 32'hFFFFFFFF; r1 = 32'hFFFFFFFF; r2 = 32'h00000001; end
            qa.push_back(64'(r0) + 64'(r1) + 64'(r2) + 64'(rc));
            send_a(rc, r0, r1, r2, 1'($urandom_range(1)));
            wait_hs_a(a_hs + 1);
        end

        qb.push_back(64'h4FFFC);
        send_b(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_hs_b(b_hs + 1);
        check("b_latency", 64'(b_lat), 64'd10);
        for (int i = 0; i < 4; i++) begin
            q0 = 16'($urandom); q1 = 16'($urandom); q2 = 16'($urandom);
            q3 = 16'($urandom); q4 = 16'($urandom); rc = 1'($urandom_range(1));
            qb.push_back(64'(q0) + 64'(q1) + 64'(q2) + 64'(q3) + 64'(q4) + 64'(rc));
            send_b(rc, q0, q1, q2, q3, q4);
            wait_hs_b(b_hs + 1);
        end

        check("a_in_ready_outside_accum", 64'(a_viol), 64'd0);
        check("b_in_ready_outside_accum", 64'(b_viol), 64'd0);
        check("a_queue_drained", 64'(qa.size()), 64'd0);
        check("b_queue_drained", 64'(qb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
